// File: rtl/crp16_writeback_queue_if.sv
`default_nettype none
// ============================================================================
// Module  : crp16_writeback_queue_if
// Brief   : Result push handshake from execute/memory into the writeback queue
// Revision: 1.0
// ============================================================================
interface crp16_writeback_queue_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_reg;
    logic [WIDTH-1:0] in_val;

    modport master (
        output in_valid,
        output in_reg,
        output in_val,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_reg,
        input  in_val,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/crp16_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module  : crp16_writeback_queue
// Brief   : In-order register-file write queue with youngest-entry forwarding
// Revision: 1.0
// ============================================================================
module crp16_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  wire logic                     clock,
    input  wire logic                     resetn,
    crp16_writeback_queue_if.slave        push,
    input  wire logic                     hold,
    output logic                          write,
    output logic [3:0]                    write_select,
    output logic [WIDTH-1:0]              load_val,
    input  wire logic [3:0]               query_a_select,
    input  wire logic [3:0]               query_b_select,
    output logic                          a_hit,
    output logic                          b_hit,
    output logic [WIDTH-1:0]              a_fwd_val,
    output logic [WIDTH-1:0]              b_fwd_val,
    output logic [$clog2(DEPTH):0]        count
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic [3:0]         r_reg [DEPTH];
    logic [WIDTH-1:0]   r_val [DEPTH];

    logic w_drain;
    logic w_ready;
    logic w_enq;

    assign w_drain = (r_count != '0) && !hold;
    assign w_ready = (r_count != c_CNT_W'(DEPTH)) || w_drain;
    // r0 is hard-wired zero: the handshake completes but nothing is stored
    assign w_enq   = push.in_valid && w_ready && (push.in_reg != 4'd0);

    assign push.in_ready = w_ready;
    assign count         = r_count;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            if (w_drain) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            case ({w_enq, w_drain})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_reg[r_tail] <= push.in_reg;
            r_val[r_tail] <= push.in_val;
        end
    end

    always_comb begin
        write        = w_drain;
        write_select = 4'd0;
        load_val     = '0;
        if (w_drain) begin
            write_select = r_reg[r_head];
            load_val     = r_val[r_head];
        end
    end

    // Walk from oldest to youngest so the last match left standing is the youngest
    function automatic logic [WIDTH:0] f_lookup(input logic [3:0] i_q);
        logic [WIDTH:0]     v_res;
        logic [c_PTR_W-1:0] v_idx;
        v_res = '0;
        for (int k = 0; k < DEPTH; k++) begin
            v_idx = r_head + c_PTR_W'(k);
            if ((c_CNT_W'(k) < r_count) && (i_q != 4'd0) && (r_reg[v_idx] == i_q)) begin
                v_res = {1'b1, r_val[v_idx]};
            end
        end
        return v_res;
    endfunction

    logic [WIDTH:0] w_look_a;
    logic [WIDTH:0] w_look_b;

    always_comb begin
        w_look_a  = f_lookup(query_a_select);
        w_look_b  = f_lookup(query_b_select);
        a_hit     = w_look_a[WIDTH];
        a_fwd_val = w_look_a[WIDTH-1:0];
        b_hit     = w_look_b[WIDTH];
        b_fwd_val = w_look_b[WIDTH-1:0];
    end
endmodule
`default_nettype wire

// File: tb/tb_crp16_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_crp16_writeback_queue
// Brief   : Directed and model-checked bench for crp16_writeback_queue
// Revision: 1.0
// ============================================================================
module tb_crp16_writeback_queue;
    localparam int DEPTH = 4;
    localparam int WIDTH = 16;

    logic             clock;
    logic             resetn;
    logic             hold;
    logic             write;
    logic [3:0]       write_select;
    logic [WIDTH-1:0] load_val;
    logic [3:0]       query_a_select;
    logic [3:0]       query_b_select;
    logic             a_hit;
    logic             b_hit;
    logic [WIDTH-1:0] a_fwd_val;
    logic [WIDTH-1:0] b_fwd_val;
    logic [2:0]       count;

    int errors = 0;
    int checks = 0;

    crp16_writeback_queue_if #(.WIDTH(WIDTH)) push_if ();

    crp16_writeback_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .push           (push_if),
        .hold           (hold),
        .write          (write),
        .write_select   (write_select),
        .load_val       (load_val),
        .query_a_select (query_a_select),
        .query_b_select (query_b_select),
        .a_hit          (a_hit),
        .b_hit          (b_hit),
        .a_fwd_val      (a_fwd_val),
        .b_fwd_val      (b_fwd_val),
        .count          (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        hold = 1'b0;
        push_if.in_valid = 1'b0;
        push_if.in_reg = 4'd0;
        push_if.in_val = '0;
        query_a_select = 4'd1;
        query_b_select = 4'd2;
        tick();
        tick();
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL reset_write got=%b exp=0", write); end
        checks++; if (write_select !== 4'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", write_select); end
        checks++; if (load_val !== 16'h0) begin errors++; $display("FAIL reset_val got=%h exp=0", load_val); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (push_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", push_if.in_ready); end
        checks++; if ({a_hit, b_hit} !== 2'b00 || a_fwd_val !== 16'h0 || b_fwd_val !== 16'h0) begin
            errors++; $display("FAIL reset_fwd got=%b%b %h %h exp=00 0 0", a_hit, b_hit, a_fwd_val, b_fwd_val);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single_push();
        push_if.in_valid = 1'b1;
        push_if.in_reg = 4'd3;
        push_if.in_val = 16'h1234;
        query_a_select = 4'd3;
        #1;
        checks++; if (push_if.in_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", push_if.in_ready); end
        checks++; if (a_hit !== 1'b0) begin errors++; $display("FAIL single_same_cycle_hit got=%b exp=0", a_hit); end
        tick();
        push_if.in_valid = 1'b0;
        #1;
        checks++; if ({write, write_select, load_val} !== {1'b1, 4'd3, 16'h1234}) begin
            errors++; $display("FAIL single_write got=%b/%0d/%h exp=1/3/1234", write, write_select, load_val);
        end
        checks++; if (a_hit !== 1'b1 || a_fwd_val !== 16'h1234) begin
            errors++; $display("FAIL single_fwd got=%b/%h exp=1/1234", a_hit, a_fwd_val);
        end
        tick();
        checks++; if (write !== 1'b0 || count !== 3'd0) begin
            errors++; $display("FAIL single_after got=%b/%0d exp=0/0", write, count);
        end
    endtask

    task automatic test_hold_fill();
        logic [3:0]  regs [4];
        logic [15:0] vals [4];
        regs = '{4'd1, 4'd2, 4'd1, 4'd5};
        vals = '{16'h0001, 16'h0002, 16'h00AA, 16'h0005};
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_if.in_valid = 1'b1;
            push_if.in_reg = regs[i];
            push_if.in_val = vals[i];
            #1;
            checks++; if (write !== 1'b0) begin errors++; $display("FAIL hold_write[%0d] got=%b exp=0", i, write); end
            tick();
        end
        push_if.in_valid = 1'b1;
        push_if.in_reg = 4'd9;
        push_if.in_val = 16'h9999;
        query_a_select = 4'd1;
        query_b_select = 4'd2;
        #1;
        checks++; if (count !== 3'd4 || push_if.in_ready !== 1'b0) begin
            errors++; $display("FAIL hold_full got=%0d/%b exp=4/0", count, push_if.in_ready);
        end
        checks++; if (a_hit !== 1'b1 || a_fwd_val !== 16'h00AA) begin
            errors++; $display("FAIL hold_fwd_a got=%b/%h exp=1/00aa", a_hit, a_fwd_val);
        end
        checks++; if (b_hit !== 1'b1 || b_fwd_val !== 16'h0002) begin
            errors++; $display("FAIL hold_fwd_b got=%b/%h exp=1/0002", b_hit, b_fwd_val);
        end
        tick();
        push_if.in_valid = 1'b0;
        query_b_select = 4'd9;
        #1;
        checks++; if (count !== 3'd4 || b_hit !== 1'b0) begin
            errors++; $display("FAIL hold_rejected got=%0d/%b exp=4/0", count, b_hit);
        end
        hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if ({write, write_select, load_val} !== {1'b1, regs[i], vals[i]}) begin
                errors++; $display("FAIL drain[%0d] got=%b/%0d/%h exp=1/%0d/%h", i, write, write_select, load_val, regs[i], vals[i]);
            end
            tick();
        end
        checks++; if (write !== 1'b0 || count !== 3'd0 || a_hit !== 1'b0) begin
            errors++; $display("FAIL drain_done got=%b/%0d/%b exp=0/0/0", write, count, a_hit);
        end
    endtask

    task automatic test_full_wrap();
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_if.in_valid = 1'b1;
            push_if.in_reg = 4'(4 + i);
            push_if.in_val = 16'(16'h0040 + 16'(i * 16));
            tick();
        end
        hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_if.in_valid = 1'b1;
            push_if.in_reg = 4'(8 + i);
            push_if.in_val = 16'(16'h0080 + 16'(i * 16));
            #1;
            checks++; if (push_if.in_ready !== 1'b1 || count !== 3'd4) begin
                errors++; $display("FAIL wrap_ready[%0d] got=%b/%0d exp=1/4", i, push_if.in_ready, count);
            end
            checks++; if (write !== 1'b1 || write_select !== 4'(4 + i) || load_val !== 16'(16'h0040 + 16'(i * 16))) begin
                errors++; $display("FAIL wrap_w1[%0d] got=%b/%0d/%h exp=1/%0d", i, write, write_select, load_val, 4 + i);
            end
            tick();
        end
        push_if.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (write !== 1'b1 || write_select !== 4'(8 + i) || load_val !== 16'(16'h0080 + 16'(i * 16))) begin
                errors++; $display("FAIL wrap_w2[%0d] got=%b/%0d/%h exp=1/%0d", i, write, write_select, load_val, 8 + i);
            end
            tick();
        end
        checks++; if (write !== 1'b0 || count !== 3'd0) begin
            errors++; $display("FAIL wrap_done got=%b/%0d exp=0/0", write, count);
        end
    endtask

    task automatic test_r0_push();
        push_if.in_valid = 1'b1;
        push_if.in_reg = 4'd0;
        push_if.in_val = 16'hFFFF;
        query_b_select = 4'd0;
        #1;
        checks++; if (push_if.in_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got=%b exp=1", push_if.in_ready); end
        tick();
        push_if.in_valid = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || write !== 1'b0) begin
            errors++; $display("FAIL r0_enq got=%0d/%b exp=0/0", count, write);
        end
        checks++; if (b_hit !== 1'b0 || b_fwd_val !== 16'h0) begin
            errors++; $display("FAIL r0_query got=%b/%h exp=0/0", b_hit, b_fwd_val);
        end
    endtask

    task automatic test_reset_mid_drain();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_if.in_valid = 1'b1;
            push_if.in_reg = 4'(2 + i);
            push_if.in_val = 16'(16'h0200 + i);
            tick();
        end
        push_if.in_valid = 1'b0;
        hold = 1'b0;
        query_a_select = 4'd2;
        query_b_select = 4'd3;
        #1;
        checks++; if (write !== 1'b1 || count !== 3'd3) begin
            errors++; $display("FAIL rst_pre got=%b/%0d exp=1/3", write, count);
        end
        resetn = 1'b0;
        #1;
        checks++; if (write !== 1'b0 || count !== 3'd0 || write_select !== 4'd0 || load_val !== 16'h0) begin
            errors++; $display("FAIL rst_async got=%b/%0d/%0d/%h exp=0/0/0/0", write, count, write_select, load_val);
        end
        tick();
        resetn = 1'b1;
        tick();
        checks++; if (a_hit !== 1'b0 || b_hit !== 1'b0 || push_if.in_ready !== 1'b1 || count !== 3'd0) begin
            errors++; $display("FAIL rst_after got=%b/%b/%b/%0d exp=0/0/1/0", a_hit, b_hit, push_if.in_ready, count);
        end
    endtask

    typedef struct packed {
        logic [3:0]  r;
        logic [15:0] v;
    } ent_t;

    task automatic test_random();
        ent_t        mq[$];
        logic [15:0] mdl_rf [16];
        logic [15:0] dut_rf [16];
        logic        exp_drain;
        logic        exp_ready;
        logic        ea_hit;
        logic        eb_hit;
        logic [15:0] ea_val;
        logic [15:0] eb_val;
        for (int i = 0; i < 16; i++) begin
            mdl_rf[i] = '0;
            dut_rf[i] = '0;
        end
        for (int c = 0; c < 300; c++) begin
            push_if.in_valid = ($urandom_range(0, 9) < 7);
            push_if.in_reg = 4'($urandom_range(0, 15));
            push_if.in_val = 16'($urandom);
            hold = (c < 280) ? ($urandom_range(0, 9) < 4) : 1'b0;
            if (c >= 280) push_if.in_valid = 1'b0;
            query_a_select = 4'($urandom_range(0, 15));
            query_b_select = 4'($urandom_range(0, 15));
            #1;
            exp_drain = (mq.size() != 0) && !hold;
            exp_ready = (mq.size() != DEPTH) || exp_drain;
            ea_hit = 1'b0; ea_val = '0; eb_hit = 1'b0; eb_val = '0;
            foreach (mq[k]) begin
                if (query_a_select != 0 && mq[k].r == query_a_select) begin ea_hit = 1'b1; ea_val = mq[k].v; end
                if (query_b_select != 0 && mq[k].r == query_b_select) begin eb_hit = 1'b1; eb_val = mq[k].v; end
            end
            checks++; if (count !== 3'(mq.size()) || push_if.in_ready !== exp_ready || write !== exp_drain) begin
                errors++; $display("FAIL rnd_ctl[%0d] got=%0d/%b/%b exp=%0d/%b/%b", c, count, push_if.in_ready, write, mq.size(), exp_ready, exp_drain);
            end
            if (exp_drain) begin
                checks++; if (write_select !== mq[0].r || load_val !== mq[0].v) begin
                    errors++; $display("FAIL rnd_wr[%0d] got=%0d/%h exp=%0d/%h", c, write_select, load_val, mq[0].r, mq[0].v);
                end
            end
            checks++; if (a_hit !== ea_hit || a_fwd_val !== ea_val || b_hit !== eb_hit || b_fwd_val !== eb_val) begin
                errors++; $display("FAIL rnd_fwd[%0d] got=%b/%h %b/%h exp=%b/%h %b/%h", c, a_hit, a_fwd_val, b_hit, b_fwd_val, ea_hit, ea_val, eb_hit, eb_val);
            end
            if (write === 1'b1) dut_rf[write_select] = load_val;
            if (exp_drain) begin
                mdl_rf[mq[0].r] = mq[0].v;
                void'(mq.pop_front());
            end
            if (push_if.in_valid && exp_ready && push_if.in_reg != 4'd0) begin
                mq.push_back('{r: push_if.in_reg, v: push_if.in_val});
            end
            tick();
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rnd_empty got=%0d exp=0", count); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (dut_rf[i] !== mdl_rf[i]) begin
                errors++; $display("FAIL rnd_rf[%0d] got=%h exp=%h", i, dut_rf[i], mdl_rf[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_hold_fill();
        test_full_wrap();
        test_r0_push();
        test_reset_mid_drain();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/crp16_writeback_queue.md
# crp16_writeback_queue

Write-side producer for the CRP16 register file. It accepts register results from the execute/memory stages over a valid/ready handshake and buffers them in a small in-order FIFO. It drains one entry per cycle onto the register file's `write` / `write_select` / `load_val` port. Two read-select lookups report and forward the youngest pending value for a register, so the decode stage can bypass results that are not yet written.

## Interface
- `DEPTH`, 4: number of queue entries; power of two, 2..16.
- `WIDTH`, 16: data width; matches the register file word.
- `clock`  in  1  rising-edge clock shared with the register file.
- `resetn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer has a result.
- `in_ready`  out  1  queue can accept a result this cycle.
- `in_reg`  in  4  destination register index.
- `in_val`  in  WIDTH  result value.
- `hold`  in  1  1 = do not drain this cycle.
- `write`  out  1  write enable to the register file.
- `write_select`  out  4  destination index to the register file.
- `load_val`  out  WIDTH  value to the register file.
- `query_a_select`, `query_b_select`  in  4  register indices being read by decode.
- `a_hit`, `b_hit`  out  1  a pending entry targets the queried register.
- `a_fwd_val`, `b_fwd_val`  out  WIDTH  value of the youngest matching pending entry.
- `count`  out  log2(DEPTH)+1  number of occupied entries.

## Operation
- Storage: circular buffer of DEPTH entries {reg[3:0], val[WIDTH-1:0]}, with a head pointer, a tail pointer and `count`. Pointers wrap modulo DEPTH.
- Push: occurs when `in_valid && in_ready`.
  - The entry is written at the tail, tail increments, count increments.
  - If `in_reg == 0`, the transfer is still accepted (handshake completes) but nothing is enqueued, because r0 is read-only zero.
- `in_ready = (count != DEPTH) || (drain this cycle)`. A full queue that is draining accepts a new entry in the same cycle.
- Drain: occurs when `count != 0 && !hold`.
  - `write` = 1, `write_select` = head.reg, `load_val` = head.val.
  - At the rising edge, head increments and count decrements.
- When not draining: `write` = 0, `write_select` = 0, `load_val` = 0.
- Simultaneous push and drain: count is unchanged, and both pointers advance.
- Drain order is strict FIFO, so multiple writes to the same register land in program order.
- Forwarding, computed combinationally over occupied entries only:
  - `a_hit` = 1 if any occupied entry has reg == `query_a_select` and `query_a_select != 0`.
  - `a_fwd_val` = val of the youngest (closest to tail) matching entry, or 0 if there is no hit.
  - Port b is identical.
  - The head entry being written this cycle still counts as pending.
  - An entry being pushed this cycle is not visible until the next cycle.
- Query of r0: hit is always 0 and value is 0.
- Reset (`resetn` low, any time, including mid-drain):
  - head, tail and count go to 0 and all entries are invalidated.
  - Outputs: `write` 0, `write_select` 0, `load_val` 0, `a_hit`/`b_hit` 0, `a_fwd_val`/`b_fwd_val` 0, `count` 0, `in_ready` 1.
  - Entry payload flops need no reset.

## Timing
- Push-to-write latency: an entry pushed at edge N is at the head after N.
  - With an empty queue and `hold` low, `write` is asserted during cycle N+1.
  - The register file captures it at edge N+1.
- Throughput: one push and one drain per cycle, sustained.
- `write`, `write_select`, `load_val` are decoded from flopped state (count, head entry) plus `hold`. There is no combinational path from `in_*` to them.
- `in_ready` depends combinationally on `hold` and count only, not on `in_valid`.
- Forwarding outputs are combinational from the queries and flopped entries.
- `hold` high freezes head and count. Pushes continue until the queue is full (count == DEPTH), then `in_ready` = 0.

## Test plan
- Reset then single push (reg 3, 0x1234), `hold` = 0:
  - Next cycle: `write` = 1, `write_select` = 3, `load_val` = 0x1234.
  - Cycle after: `write` = 0, `count` = 0.
- `hold` = 1, push 4 entries (r1=0x0001, r2=0x0002, r1=0x00AA, r5=0x0005):
  - `count` = 4, `in_ready` = 0.
  - `query_a_select` = 1 gives `a_hit` = 1, `a_fwd_val` = 0x00AA.
  - Release `hold`: writes r1, r2, r1, r5 in order on 4 consecutive cycles.
- Full queue with `hold` = 0 plus `in_valid`:
  - `in_ready` = 1 and `count` stays 4.
  - Pointers wrap past DEPTH-1 without losing or duplicating entries.
- Push to r0 (value 0xFFFF):
  - Handshake completes, `count` unchanged, no `write` issued.
  - `query_b_select` = 0 gives `b_hit` = 0, `b_fwd_val` = 0.
- Assert `resetn` = 0 while 3 entries are pending and `write` = 1:
  - `write` drops immediately, `count` = 0.
  - After release, queries give no hits and `in_ready` = 1.
- Random push/hold traffic checked against a reference model of the 16-register file:
  - Final register contents match.
  - Forwarded values always equal the model's latest pending value.
